// File: rtl/mem_stage_unit.sv
// mem_stage_unit -- pipeline memory stage between the EX/MEM and MEM/WB latches.
//
// Purpose:
//   Issues data-cache requests and generates per-lane byte enables for
//   byte/half/word/doubleword accesses (little-endian lane map).
//   Replicates store data across lanes, and sign- or zero-extends loads.
//   A two-state request FSM (IDLE/HOLD) keeps a completed access from being
//   re-issued while the pipeline is stalled. The block also owns the MEM/WB
//   output latch, which advances on ihit and is squashed by flush.
//
// Parameters: DW (32 or 64) data width, AW address width,
//             RW register index width, SW regSel width.
//
// Ports:
//   CLK, nRST              clock, synchronous active-low reset
//   in_*                   EX/MEM entry (valid, nPC, dREN/dWEN, size, unsigned,
//                          regWr, regSel, regDst, ALUOut, rtdat, halt)
//   ihit, flush            pipeline advance enable / squash
//   dmemload, dhit         cache read data / access complete
//   dmemREN, dmemWEN       cache read/write request
//   dmemaddr, dmemstore    lane-aligned address / lane-replicated store data
//   dmembyteen             active lanes
//   mem_busy               request outstanding, upstream must stall
//   out_*                  MEM/WB latch, out_load = extended load data
//
// Optional feature: define MISALIGN_TRAP_EN to add out_misalign and suppress
// misaligned accesses. When it is left undefined, the misaligned low address
// bits are truncated by the lane map.
module mem_stage_unit #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int RW = 5,
  parameter int SW = 3
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          in_valid,
  input  logic [AW-1:0] in_nPC,
  input  logic          in_dREN,
  input  logic          in_dWEN,
  input  logic [1:0]    in_size,
  input  logic          in_unsigned,
  input  logic          in_regWr,
  input  logic [SW-1:0] in_regSel,
  input  logic [RW-1:0] in_regDst,
  input  logic [DW-1:0] in_ALUOut,
  input  logic [DW-1:0] in_rtdat,
  input  logic          in_halt,
  input  logic          ihit,
  input  logic          flush,
  input  logic [DW-1:0] dmemload,
  input  logic          dhit,
  output logic          dmemREN,
  output logic          dmemWEN,
  output logic [AW-1:0] dmemaddr,
  output logic [DW-1:0] dmemstore,
  output logic [DW/8-1:0] dmembyteen,
  output logic          mem_busy,
  output logic          out_valid,
  output logic [AW-1:0] out_nPC,
  output logic          out_regWr,
  output logic [SW-1:0] out_regSel,
  output logic [RW-1:0] out_regDst,
  output logic [DW-1:0] out_ALUOut,
  output logic          out_halt,
  output logic [DW-1:0] out_load
`ifdef MISALIGN_TRAP_EN
  ,
  output logic          out_misalign
`endif
);

  localparam int NL = DW / 8;
  localparam int OW = $clog2(NL);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} stateT;

  stateT         state;
  logic [DW-1:0] dataQ;
  logic [1:0]    sizeEff;
  logic [OW-1:0] off;
  logic [OW-1:0] alignOff;
  logic          memAcc;
  logic          memop;
  logic          misalign;
  logic          reqOk;
  logic [DW-1:0] shifted;
  logic [DW-1:0] mask;
  logic          signBit;
  logic [DW-1:0] extLoad;
  logic          latchEn;

  assign off      = in_ALUOut[OW-1:0];
  assign memAcc   = in_valid & (in_dREN | in_dWEN) & ~in_halt;
  assign memop    = memAcc & ~flush;
  assign reqOk    = memop & ~misalign;
  assign dmemaddr = {in_ALUOut[AW-1:OW], {OW{1'b0}}};
  assign latchEn  = ihit & ~mem_busy;

  // Effective access size: a 32-bit datapath has no doubleword, so 11 acts as word.
  always_comb begin
    if (DW == 32 && in_size == 2'b11) begin
      sizeEff = 2'b10;
    end else begin
      sizeEff = in_size;
    end
  end

  // Lane offset of the access with the low bits ignored for the access size.
  always_comb begin
    case (sizeEff)
      2'b00:   alignOff = off;
      2'b01:   alignOff = off & ~OW'(2'b01);
      2'b10:   alignOff = off & ~OW'(2'b11);
      default: alignOff = {OW{1'b0}};
    endcase
  end

  // Byte enables and store-data replication per access size.
  always_comb begin
    case (sizeEff)
      2'b00: begin
        dmembyteen = NL'(1'b1) << off;
        dmemstore  = {NL{in_rtdat[7:0]}};
      end
      2'b01: begin
        dmembyteen = NL'(2'b11) << alignOff;
        dmemstore  = {(NL/2){in_rtdat[15:0]}};
      end
      2'b10: begin
        dmembyteen = NL'(4'b1111) << alignOff;
        dmemstore  = {(NL/4){in_rtdat[31:0]}};
      end
      default: begin
        dmembyteen = {NL{1'b1}};
        dmemstore  = in_rtdat;
      end
    endcase
  end

  // Load extraction: shift the addressed lanes down, then mask and extend.
  always_comb begin
    shifted = dmemload >> {alignOff, 3'b000};
    case (sizeEff)
      2'b00: begin
        mask    = DW'(8'hFF);
        signBit = shifted[7];
      end
      2'b01: begin
        mask    = DW'(16'hFFFF);
        signBit = shifted[15];
      end
      2'b10: begin
        mask    = DW'(32'hFFFF_FFFF);
        signBit = shifted[31];
      end
      default: begin
        mask    = {DW{1'b1}};
        signBit = 1'b0;
      end
    endcase
    if (signBit & ~in_unsigned) begin
      extLoad = (shifted & mask) | ~mask;
    end else begin
      extLoad = shifted & mask;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Misalignment detection; only meaningful for a real memory access.
  always_comb begin
    case (sizeEff)
      2'b01:   misalign = memAcc & off[0];
      2'b10:   misalign = memAcc & (off[1:0] != 2'b00);
      2'b11:   misalign = memAcc & (off != {OW{1'b0}});
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Cache request and stall outputs; HOLD means the access already completed.
  always_comb begin
    case (state)
      IDLE: begin
        dmemREN  = reqOk & in_dREN;
        dmemWEN  = reqOk & in_dWEN;
        mem_busy = reqOk & ~dhit;
      end
      default: begin
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        mem_busy = 1'b0;
      end
    endcase
  end

  // Request FSM, held load data and the MEM/WB output latch.
  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      state      <= IDLE;
      dataQ      <= {DW{1'b0}};
      out_valid  <= 1'b0;
      out_nPC    <= {AW{1'b0}};
      out_regWr  <= 1'b0;
      out_regSel <= {SW{1'b0}};
      out_regDst <= {RW{1'b0}};
      out_ALUOut <= {DW{1'b0}};
      out_halt   <= 1'b0;
      out_load   <= {DW{1'b0}};
`ifdef MISALIGN_TRAP_EN
      out_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Access finished but the pipeline is stalled: park the result.
          if (reqOk & dhit & ~ihit) begin
            dataQ <= in_dREN ? extLoad : {DW{1'b0}};
            state <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (ihit) begin
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase

      if (latchEn) begin
        out_valid  <= in_valid;
        out_nPC    <= in_nPC;
        out_regWr  <= in_regWr & ~misalign;
        out_regSel <= in_regSel;
        out_regDst <= in_regDst;
        out_ALUOut <= in_ALUOut;
        out_halt   <= in_halt;
`ifdef MISALIGN_TRAP_EN
        out_misalign <= misalign;
`endif
        if (state == HOLD) begin
          out_load <= dataQ;
        end else if (reqOk & in_dREN) begin
          out_load <= extLoad;
        end else begin
          out_load <= {DW{1'b0}};
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit (DW=32). Expected MEM/WB latch
// contents are pushed to a scoreboard queue when an entry is driven and
// popped when the latch is seen to advance.
module tb_mem_stage_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid, in_dREN, in_dWEN, in_unsigned, in_regWr, in_halt;
  logic [31:0] in_nPC, in_ALUOut, in_rtdat, dmemload;
  logic [1:0]  in_size;
  logic [2:0]  in_regSel;
  logic [4:0]  in_regDst;
  logic        ihit, flush, dhit;
  logic        dmemREN, dmemWEN, mem_busy;
  logic [31:0] dmemaddr, dmemstore;
  logic [3:0]  dmembyteen;
  logic        out_valid, out_regWr, out_halt;
  logic [31:0] out_nPC, out_ALUOut, out_load;
  logic [2:0]  out_regSel;
  logic [4:0]  out_regDst;
`ifdef MISALIGN_TRAP_EN
  logic        out_misalign;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [31:0] nPC;
    logic        regWr;
    logic [2:0]  regSel;
    logic [4:0]  regDst;
    logic [31:0] alu;
    logic        halt;
    logic [31:0] load;
    logic        mis;
  } expT;

  expT sb[$];

  mem_stage_unit #(.DW(32), .AW(32), .RW(5), .SW(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_nPC(in_nPC), .in_dREN(in_dREN), .in_dWEN(in_dWEN),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_regWr(in_regWr),
    .in_regSel(in_regSel), .in_regDst(in_regDst), .in_ALUOut(in_ALUOut),
    .in_rtdat(in_rtdat), .in_halt(in_halt), .ihit(ihit), .flush(flush),
    .dmemload(dmemload), .dhit(dhit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmembyteen(dmembyteen),
    .mem_busy(mem_busy), .out_valid(out_valid), .out_nPC(out_nPC),
    .out_regWr(out_regWr), .out_regSel(out_regSel), .out_regDst(out_regDst),
    .out_ALUOut(out_ALUOut), .out_halt(out_halt), .out_load(out_load)
`ifdef MISALIGN_TRAP_EN
    , .out_misalign(out_misalign)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one entry, run dhit/ihit timing, count request/busy cycles, and
  // compare the latch against the scoreboard when it advances.
  task automatic runTxn(input string tag, input logic ren, input logic wen,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rtdat,
                        input logic [31:0] memload, input logic halt,
                        input int dhitDly, input int ihitLow,
                        input logic [31:0] expLoad, input logic [3:0] expBe,
                        input logic [31:0] expStore, input int expReq,
                        input int expBusy, input logic expMis);
    expT e;
    expT g;
    int reqCnt = 0;
    int busyCnt = 0;
    logic firstReq = 1'b1;
    logic done = 1'b0;
    logic acc;
    @(negedge CLK);
    in_valid = 1'b1; in_dREN = ren; in_dWEN = wen; in_size = size;
    in_unsigned = uns; in_ALUOut = addr; in_rtdat = rtdat; in_halt = halt;
    in_nPC = $urandom; in_regWr = 1'b1;
    in_regSel = 3'($urandom_range(7, 0)); in_regDst = 5'($urandom_range(31, 0));
    dmemload = memload;
    e.valid = 1'b1; e.nPC = in_nPC; e.regWr = ~expMis; e.regSel = in_regSel;
    e.regDst = in_regDst; e.alu = addr; e.halt = halt; e.load = expLoad; e.mis = expMis;
    sb.push_back(e);
    for (int c = 0; c < 20 && !done; c++) begin
      dhit = (c >= dhitDly);
      ihit = (c >= ihitLow);
      #1;
      if (dmemREN | dmemWEN) begin
        reqCnt++;
        if (firstReq) begin
          firstReq = 1'b0;
          checkVal({tag, "_rw"}, {62'd0, dmemREN, dmemWEN}, {62'd0, ren, wen});
          checkVal({tag, "_addr"}, 64'(dmemaddr), 64'(addr & 32'hFFFF_FFFC));
          checkVal({tag, "_be"}, 64'(dmembyteen), 64'(expBe));
          if (wen) checkVal({tag, "_store"}, 64'(dmemstore), 64'(expStore));
        end
      end
      if (mem_busy) busyCnt++;
      acc = ihit & ~mem_busy;
      @(posedge CLK);
      #1;
      if (acc) begin
        done = 1'b1;
        g = sb.pop_front();
        checkVal({tag, "_valid"}, 64'(out_valid), 64'(g.valid));
        checkVal({tag, "_nPC"}, 64'(out_nPC), 64'(g.nPC));
        checkVal({tag, "_regWr"}, 64'(out_regWr), 64'(g.regWr));
        checkVal({tag, "_regSel"}, 64'(out_regSel), 64'(g.regSel));
        checkVal({tag, "_regDst"}, 64'(out_regDst), 64'(g.regDst));
        checkVal({tag, "_alu"}, 64'(out_ALUOut), 64'(g.alu));
        checkVal({tag, "_halt"}, 64'(out_halt), 64'(g.halt));
        checkVal({tag, "_load"}, 64'(out_load), 64'(g.load));
`ifdef MISALIGN_TRAP_EN
        checkVal({tag, "_mis"}, 64'(out_misalign), 64'(g.mis));
`endif
      end else begin
        @(negedge CLK);
      end
    end
    if (!done) begin
      checkVal({tag, "_timeout"}, 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    checkVal({tag, "_reqCnt"}, 64'(reqCnt), 64'(expReq));
    checkVal({tag, "_busyCnt"}, 64'(busyCnt), 64'(expBusy));
  endtask

  initial begin
    // Reset with an active load presented: the latch must still clear.
    nRST = 1'b0; flush = 1'b0; ihit = 1'b1; dhit = 1'b1;
    in_valid = 1'b1; in_dREN = 1'b1; in_dWEN = 1'b0; in_size = 2'b10;
    in_unsigned = 1'b0; in_regWr = 1'b1; in_regSel = 3'd2; in_regDst = 5'd7;
    in_nPC = 32'h44; in_ALUOut = 32'h100; in_rtdat = 32'd0; in_halt = 1'b0;
    dmemload = 32'h1234_5678;
    repeat (2) @(posedge CLK);
    #1;
    checkVal("rst_valid", 64'(out_valid), 64'd0);
    checkVal("rst_regWr", 64'(out_regWr), 64'd0);
    checkVal("rst_load", 64'(out_load), 64'd0);
    checkVal("rst_nPC", 64'(out_nPC), 64'd0);
    @(negedge CLK);
    nRST = 1'b1; in_valid = 1'b0;

    //      tag       ren   wen   size   uns   addr          rtdat         memload       halt dly ilo expLoad        be       store         req busy mis
    runTxn("wload",   1'b1, 1'b0, 2'b10, 1'b0, 32'h104,      32'h0,        32'hDEAD_BEEF, 1'b0, 2, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        3, 2, 1'b0);
    runTxn("bstore",  1'b0, 1'b1, 2'b00, 1'b0, 32'h13,       32'h1234_56AB, 32'h0,        1'b0, 0, 0, 32'h0,         4'b1000, 32'hABAB_ABAB, 1, 0, 1'b0);
    runTxn("sbload",  1'b1, 1'b0, 2'b00, 1'b0, 32'h22,       32'h0,        32'h0080_0000, 1'b0, 1, 0, 32'hFFFF_FF80, 4'b0100, 32'h0,        2, 1, 1'b0);
    runTxn("uhload",  1'b1, 1'b0, 2'b01, 1'b1, 32'h1A,       32'h0,        32'h8001_0000, 1'b0, 0, 0, 32'h0000_8001, 4'b1100, 32'h0,        1, 0, 1'b0);
    runTxn("shload",  1'b1, 1'b0, 2'b01, 1'b0, 32'h30,       32'h0,        32'h1234_F00D, 1'b0, 0, 0, 32'hFFFF_F00D, 4'b0011, 32'h0,        1, 0, 1'b0);
    runTxn("ubload",  1'b1, 1'b0, 2'b00, 1'b1, 32'h47,       32'h0,        32'h9A00_0000, 1'b0, 0, 0, 32'h0000_009A, 4'b1000, 32'h0,        1, 0, 1'b0);
    runTxn("dwload",  1'b1, 1'b0, 2'b11, 1'b0, 32'h50,       32'h0,        32'hCAFE_F00D, 1'b0, 0, 0, 32'hCAFE_F00D, 4'b1111, 32'h0,        1, 0, 1'b0);
    runTxn("hstore",  1'b0, 1'b1, 2'b01, 1'b0, 32'h62,       32'hAAAA_5678, 32'h0,        1'b0, 1, 0, 32'h0,         4'b1100, 32'h5678_5678, 2, 1, 1'b0);
    runTxn("holdst",  1'b0, 1'b1, 2'b10, 1'b0, 32'h70,       32'h1122_3344, 32'h0,        1'b0, 0, 3, 32'h0,         4'b1111, 32'h1122_3344, 1, 0, 1'b0);
    runTxn("holdld",  1'b1, 1'b0, 2'b00, 1'b0, 32'h75,       32'h0,        32'h0000_7F00, 1'b0, 1, 4, 32'h0000_007F, 4'b0010, 32'h0,        2, 1, 1'b0);
    runTxn("halt",    1'b1, 1'b0, 2'b10, 1'b0, 32'h80,       32'h0,        32'hFFFF_FFFF, 1'b1, 0, 0, 32'h0,         4'b1111, 32'h0,        0, 0, 1'b0);
    runTxn("nop",     1'b0, 1'b0, 2'b10, 1'b0, 32'h5555,     32'h0,        32'hFFFF_FFFF, 1'b0, 3, 0, 32'h0,         4'b1111, 32'h0,        0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    runTxn("mishalf", 1'b1, 1'b0, 2'b01, 1'b0, 32'h201,      32'h0,        32'h0000_8123, 1'b0, 0, 0, 32'h0,         4'b0011, 32'h0,        0, 0, 1'b1);
    runTxn("misword", 1'b0, 1'b1, 2'b10, 1'b0, 32'h302,      32'h0,        32'h0,         1'b0, 0, 0, 32'h0,         4'b1111, 32'h0,        0, 0, 1'b1);
`else
    runTxn("trunch",  1'b1, 1'b0, 2'b01, 1'b0, 32'h201,      32'h0,        32'h0000_8123, 1'b0, 0, 0, 32'hFFFF_8123, 4'b0011, 32'h0,        1, 0, 1'b0);
`endif

    // Store completes while stalled (HOLD), then flush; next access starts in IDLE.
    @(negedge CLK);
    in_valid = 1'b1; in_dREN = 1'b0; in_dWEN = 1'b1; in_size = 2'b10;
    in_halt = 1'b0; in_ALUOut = 32'h90; in_rtdat = 32'h0BAD_F00D; dhit = 1'b1; ihit = 1'b0;
    #1 checkVal("fl_wen0", 64'(dmemWEN), 64'd1);
    @(negedge CLK);
    #1 checkVal("fl_holdwen", 64'(dmemWEN), 64'd0);
    checkVal("fl_holdbusy", 64'(mem_busy), 64'd0);
    flush = 1'b1;
    @(posedge CLK);
    #1 checkVal("fl_valid1", 64'(out_valid), 64'd0);
    @(negedge CLK);
    flush = 1'b0; in_dREN = 1'b1; in_dWEN = 1'b0; in_ALUOut = 32'hA0; dhit = 1'b0; ihit = 1'b1;
    #1 checkVal("fl_idleren", 64'(dmemREN), 64'd1);
    checkVal("fl_busy", 64'(mem_busy), 64'd1);
    flush = 1'b1;
    #1 checkVal("fl_rendrop", 64'(dmemREN), 64'd0);
    checkVal("fl_busydrop", 64'(mem_busy), 64'd0);
    @(posedge CLK);
    #1 checkVal("fl_valid2", 64'(out_valid), 64'd0);
    checkVal("fl_regWr2", 64'(out_regWr), 64'd0);
    @(negedge CLK);
    flush = 1'b0;

    // Non-memory entry fills the latch, then reset with a pending load.
    runTxn("nop2",    1'b0, 1'b0, 2'b00, 1'b0, 32'h7777,     32'h0,        32'h0,         1'b0, 5, 0, 32'h0,         4'b0001, 32'h0,        0, 0, 1'b0);
    @(negedge CLK);
    in_valid = 1'b1; in_dREN = 1'b1; in_dWEN = 1'b0; in_ALUOut = 32'hB0; dhit = 1'b0; ihit = 1'b1;
    #1 checkVal("mr_ren", 64'(dmemREN), 64'd1);
    nRST = 1'b0;
    @(posedge CLK);
    #1 checkVal("mr_valid", 64'(out_valid), 64'd0);
    checkVal("mr_alu", 64'(out_ALUOut), 64'd0);
    @(negedge CLK);
    nRST = 1'b1; in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
